// File: rtl/pi_code_ctrl.sv
// Phase-interpolator code controller for the XAUI CDR loop.
// Integrates phase-detector up/dn votes into a saturating accumulator and
// steps the PI code by one LSB when the net vote count reaches THRESH,
// with a minimum settling gap between steps. The code wraps modulo
// 2^CODE_W (top two bits = quadrant, low bits = fine step). The block also
// provides a manual load, a freeze, and a dither-based lock indicator.
module pi_code_ctrl #(
    parameter int CODE_W  = 6,
    parameter int FILT_W  = 4,
    parameter int THRESH  = 4,
    parameter int MIN_GAP = 8,
    parameter int LOCK_N  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              dn,
    input  logic              freeze,
    input  logic              load,
    input  logic [CODE_W-1:0] load_code,
    output logic [CODE_W-1:0] code,
    output logic              code_upd,
    output logic              wrap,
    output logic              lock
);

    localparam int ACC_W = FILT_W + 1;
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int LCK_W = $clog2(LOCK_N + 1);

    localparam logic signed [ACC_W:0]   ACC_MAX_X = (ACC_W + 1)'((2 ** FILT_W) - 1);
    localparam logic signed [ACC_W:0]   ACC_MIN_X = -ACC_MAX_X;
    localparam logic signed [ACC_W-1:0] THR_P     = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_N     = -THR_P;
    localparam logic [GAP_W-1:0]        GAP_LOAD  = GAP_W'(MIN_GAP - 1);
    localparam logic [LCK_W-1:0]        LCK_MAX   = LCK_W'(LOCK_N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]               state;
    logic signed [ACC_W-1:0]  acc;
    logic [GAP_W-1:0]         gap;
    logic [LCK_W-1:0]         lock_cnt;
    logic                     dir_vld;
    logic                     dir_up;

    logic signed [ACC_W:0]    vote;
    logic signed [ACC_W:0]    acc_sum;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic                     active;
    logic                     gap_zero;
    logic                     step_up;
    logic                     step_dn;

    // Clamp the one-bit-wider vote sum back into the accumulator range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] x);
        logic signed [ACC_W:0] y;
        y = x;
        if (x > ACC_MAX_X) begin
            y = ACC_MAX_X;
        end else if (x < ACC_MIN_X) begin
            y = ACC_MIN_X;
        end
        return y[ACC_W-1:0];
    endfunction

    // Vote decode, saturating accumulation and step decision for this cycle.
    always_comb begin
        vote = '0;
        if (up && !dn) begin
            vote = (ACC_W + 1)'(1);
        end else if (dn && !up) begin
            vote = '1;
        end
        acc_sum  = $signed({acc[ACC_W-1], acc}) + vote;
        acc_nxt  = sat_acc(acc_sum);
        active   = (state == S_RUN) && en && !freeze;
        gap_zero = (gap == '0);
        step_up  = active && gap_zero && (acc_nxt >= THR_P);
        step_dn  = active && gap_zero && (acc_nxt <= THR_N) && !step_up;
    end

    // Loop-control state machine; en=0 overrides freeze from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (en) state <= S_RUN;
                S_RUN:   if (!en) state <= S_IDLE; else if (freeze) state <= S_HOLD;
                S_HOLD:  if (!en) state <= S_IDLE; else if (!freeze) state <= S_RUN;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Code, accumulator, gap timer, lock tracking and one-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code     <= '0;
            acc      <= '0;
            gap      <= '0;
            lock_cnt <= '0;
            dir_vld  <= 1'b0;
            dir_up   <= 1'b0;
            code_upd <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            code_upd <= 1'b0;
            wrap     <= 1'b0;
            if (load) begin
                // Manual load wins over any step; it restarts settling and
                // forgets direction history so lock has to be re-earned.
                code     <= load_code;
                code_upd <= (load_code != code);
                acc      <= '0;
                gap      <= GAP_LOAD;
                lock_cnt <= '0;
                dir_vld  <= 1'b0;
            end else if (!en) begin
                acc      <= '0;
                lock_cnt <= '0;
                dir_vld  <= 1'b0;
            end else if (active) begin
                if (step_up || step_dn) begin
                    code     <= step_up ? code + CODE_W'(1) : code - CODE_W'(1);
                    code_upd <= 1'b1;
                    wrap     <= step_up ? (code == '1) : (code == '0);
                    acc      <= '0;
                    gap      <= GAP_LOAD;
                    dir_vld  <= 1'b1;
                    dir_up   <= step_up;
                    if (dir_vld) begin
                        if (dir_up != step_up) begin
                            if (lock_cnt != LCK_MAX) lock_cnt <= lock_cnt + LCK_W'(1);
                        end else begin
                            lock_cnt <= '0;
                        end
                    end
                end else begin
                    acc <= acc_nxt;
                    if (!gap_zero) gap <= gap - GAP_W'(1);
                end
            end
        end
    end

    assign lock = (lock_cnt == LCK_MAX);

endmodule

// File: tb/tb_pi_code_ctrl.sv
// Bench for pi_code_ctrl: two instances (MIN_GAP=8 and MIN_GAP=1) share one
// stimulus stream; an integer-arithmetic reference model predicts every
// output each cycle, and directed sections pin hand-computed values.
module tb_pi_code_ctrl;

    localparam int THR    = 4;
    localparam int LOCKN  = 4;
    localparam int AMAX   = 15;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    typedef struct packed {
        int   mode;
        int   acc;
        int   code;
        int   gap;
        int   lcnt;
        int   ldir;
        logic upd;
        logic wrp;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       dn = 1'b0;
    logic       freeze = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_code = '0;

    logic [5:0] code_a, code_b;
    logic       upd_a, upd_b, wrap_a, wrap_b, lock_a, lock_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    mdl_t ma, mb;

    always #5 clk = ~clk;

    pi_code_ctrl #(.CODE_W(6), .FILT_W(4), .THRESH(4), .MIN_GAP(8), .LOCK_N(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .dn(dn), .freeze(freeze),
        .load(load), .load_code(load_code),
        .code(code_a), .code_upd(upd_a), .wrap(wrap_a), .lock(lock_a)
    );

    pi_code_ctrl #(.CODE_W(6), .FILT_W(4), .THRESH(4), .MIN_GAP(1), .LOCK_N(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .dn(dn), .freeze(freeze),
        .load(load), .load_code(load_code),
        .code(code_b), .code_upd(upd_b), .wrap(wrap_b), .lock(lock_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Next model state from the loop rules, using plain integer arithmetic.
    function automatic mdl_t mdl_next(input mdl_t s, input int gapn, input logic i_en,
                                      input logic i_up, input logic i_dn, input logic i_frz,
                                      input logic i_ld, input logic [5:0] i_lc);
        mdl_t n;
        int   v, a, dir, nc;
        logic act;
        n = s;
        n.upd = 1'b0;
        n.wrp = 1'b0;
        v = (i_up && !i_dn) ? 1 : ((i_dn && !i_up) ? -1 : 0);
        a = s.acc + v;
        if (a > AMAX) a = AMAX;
        if (a < -AMAX) a = -AMAX;
        act = (s.mode == M_RUN) && i_en && !i_frz;
        if (!i_en) n.mode = M_IDLE;
        else if (s.mode == M_IDLE) n.mode = M_RUN;
        else if (s.mode == M_RUN && i_frz) n.mode = M_HOLD;
        else if (s.mode == M_HOLD && !i_frz) n.mode = M_RUN;
        if (i_ld) begin
            n.upd  = (int'(i_lc) != s.code);
            n.code = int'(i_lc);
            n.acc  = 0;
            n.gap  = gapn - 1;
            n.lcnt = 0;
            n.ldir = 0;
        end else if (!i_en) begin
            n.acc  = 0;
            n.lcnt = 0;
            n.ldir = 0;
        end else if (act) begin
            dir = 0;
            if (s.gap == 0 && a >= THR) dir = 1;
            else if (s.gap == 0 && a <= -THR) dir = -1;
            if (dir != 0) begin
                nc     = s.code + dir;
                n.wrp  = (nc < 0) || (nc > 63);
                n.code = nc & 63;
                n.upd  = 1'b1;
                n.acc  = 0;
                n.gap  = gapn - 1;
                if (s.ldir != 0) n.lcnt = (dir != s.ldir) ? ((s.lcnt + 1 > LOCKN) ? LOCKN : s.lcnt + 1) : 0;
                n.ldir = dir;
            end else begin
                n.acc = a;
                if (s.gap > 0) n.gap = s.gap - 1;
            end
        end
        return n;
    endfunction

    // Reference model update, tracking the DUTs edge for edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= mdl_next(ma, 8, en, up, dn, freeze, load, load_code);
            mb <= mdl_next(mb, 1, en, up, dn, freeze, load, load_code);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("code_a", int'(code_a), ma.code);
        chk("upd_a",  int'(upd_a),  int'(ma.upd));
        chk("wrap_a", int'(wrap_a), int'(ma.wrp));
        chk("lock_a", int'(lock_a), (ma.lcnt == LOCKN) ? 1 : 0);
        chk("code_b", int'(code_b), mb.code);
        chk("upd_b",  int'(upd_b),  int'(mb.upd));
        chk("wrap_b", int'(wrap_b), int'(mb.wrp));
        chk("lock_b", int'(lock_b), (mb.lcnt == LOCKN) ? 1 : 0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [5:0] v);
        load = 1'b1;
        load_code = v;
        tick(1);
        load = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pu, pd;
        tick(2);
        chk("rst_code", int'(code_a), 0);
        chk("rst_lock", int'(lock_a), 0);
        rst_n = 1'b1;

        // Constant up votes from reset.
        en = 1'b1; up = 1'b1;
        tick(4);
        chk("first_step_wait", int'(code_a), 0);
        tick(1);
        chk("first_step", int'(code_a), 1);
        chk("first_upd", int'(upd_a), 1);
        tick(7);
        chk("gap_hold", int'(code_a), 1);
        chk("gap_hold_upd", int'(upd_a), 0);
        tick(1);
        chk("second_step", int'(code_a), 2);
        chk("nogap_steps", int'(code_b), 3);

        // Wrap upward from 3F, then load equal value and wrap downward.
        do_load(6'h3F);
        chk("load_3f", int'(code_a), 63);
        chk("load_3f_upd", int'(upd_a), 1);
        tick(7);
        chk("pre_wrap", int'(code_a), 63);
        tick(1);
        chk("wrap_up_code", int'(code_a), 0);
        chk("wrap_up_flag", int'(wrap_a), 1);
        chk("wrap_up_upd", int'(upd_a), 1);
        up = 1'b0; dn = 1'b1;
        do_load(6'h00);
        chk("load_same_upd", int'(upd_a), 0);
        tick(8);
        chk("wrap_dn_code", int'(code_a), 63);
        chk("wrap_dn_flag", int'(wrap_a), 1);

        // Alternating bursts on the no-gap instance build lock.
        dn = 1'b0;
        do_load(6'h00);
        for (int i = 0; i < 4; i++) begin
            up = ~i[0]; dn = i[0];
            tick(4);
        end
        chk("lock_pre", int'(lock_b), 0);
        up = 1'b1; dn = 1'b0;
        tick(4);
        chk("lock_set", int'(lock_b), 1);
        tick(4);
        chk("lock_clr", int'(lock_b), 0);

        // Freeze holds the accumulator at +2.
        up = 1'b0;
        do_load(6'd5);
        up = 1'b1;
        tick(2);
        up = 1'b0; dn = 1'b1; freeze = 1'b1;
        tick(20);
        chk("freeze_code", int'(code_a), 5);
        freeze = 1'b0;
        tick(6);
        chk("thaw_wait", int'(code_a), 5);
        tick(1);
        chk("thaw_step", int'(code_a), 4);

        // Load on the same edge the threshold is reached.
        dn = 1'b0;
        do_load(6'd10);
        up = 1'b1;
        tick(7);
        chk("pre_load_thr", int'(code_a), 10);
        do_load(6'd20);
        chk("load_thr_code", int'(code_a), 20);
        chk("load_thr_upd", int'(upd_a), 1);
        chk("load_thr_wrap", int'(wrap_a), 0);
        chk("load_thr_lock", int'(lock_a), 0);

        // Cancelling votes, en drop mid-accumulation, reset mid-gap.
        dn = 1'b1;
        tick(50);
        chk("both_votes", int'(code_a), 20);
        dn = 1'b0;
        tick(2);
        en = 1'b0;
        tick(1);
        en = 1'b1;
        tick(4);
        chk("acc_cleared", int'(code_a), 20);
        tick(1);
        chk("post_idle_step", int'(code_a), 21);
        tick(2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_code", int'(code_a), 0);
        chk("async_upd", int'(upd_a), 0);
        chk("async_wrap", int'(wrap_a), 0);
        chk("async_lock_b", int'(lock_b), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(5);
        chk("restart_step", int'(code_a), 1);

        // Randomized traffic with biased vote mixes.
        pu = 50; pd = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0: begin pu = 80; pd = 15; end
                    1: begin pu = 15; pd = 80; end
                    default: begin pu = 50; pd = 50; end
                endcase
            end
            up     = ($urandom_range(0, 99) < pu);
            dn     = ($urandom_range(0, 99) < pd);
            en     = ($urandom_range(0, 99) < 95);
            freeze = ($urandom_range(0, 99) < 4);
            load   = ($urandom_range(0, 99) < 2);
            load_code = ($urandom_range(0, 3) == 0) ? 6'(ma.code) : 6'($urandom_range(0, 63));
            rst_n  = !($urandom_range(0, 999) < 3);
            tick(1);
            rst_n  = 1'b1;
        end
        load = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pi_code_ctrl.md
Name: pi_code_ctrl

Overview:
- Digital phase-interpolator code controller for the XAUI CDR loop.
- Integrates up/dn votes from the phase detector and steps the PI code one LSB per decision, with a settling-gap limit.
- Code wraps modulo 2^CODE_W: top 2 bits select the quadrant clock (0/90/180/270), the remaining bits select the fine step within that quadrant.
- Drives the vs input of the pi model. Adds a manual load, a freeze, and a lock indicator.

Parameters:
- CODE_W, 6, PI code width; MSB pair = quadrant, CODE_W-2 LSBs = fine step.
- FILT_W, 4, vote accumulator magnitude width; acc range is ±(2^FILT_W-1).
- THRESH, 4, net vote count that triggers a step; legal range 1..2^FILT_W-1.
- MIN_GAP, 8, minimum clk cycles between two consecutive code steps (PI settling).
- LOCK_N, 4, consecutive non-monotonic decisions required to assert lock.

Ports:
- clk, input, 1, controller clock (recovered/divided clock domain).
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, loop enable.
- up, input, 1, phase-detector early vote (sampled every clk).
- dn, input, 1, phase-detector late vote (sampled every clk).
- freeze, input, 1, hold code and accumulator.
- load, input, 1, one-cycle strobe to force code.
- load_code, input, CODE_W, value forced on load.
- code, output, CODE_W, registered PI code (to pi.vs).
- code_upd, output, 1, one-cycle pulse on every code change.
- wrap, output, 1, one-cycle pulse when code wraps (max->0 or 0->max).
- lock, output, 1, loop dithering about a fixed phase.

Behaviour:
- Reset (rst_n low, async) sets: code=0, acc=0, gap counter=0, lock counter=0, state=IDLE, code_upd=0, wrap=0, lock=0.
- States: IDLE, RUN, HOLD.
  - IDLE: en=0. acc cleared, lock cleared, code held. Go to RUN when en=1.
  - RUN: en=1, freeze=0. Go to HOLD when freeze=1. Go to IDLE when en=0.
  - HOLD: votes ignored; acc, code and gap counter frozen; lock held. Back to RUN when freeze=0. Go to IDLE when en=0 (en=0 has priority over freeze).
- Vote accumulation in RUN, per cycle:
  - up&!dn: +1.
  - dn&!up: -1.
  - both or neither: 0.
  - acc saturates at ±(2^FILT_W-1).
- Step decision: let acc_next = acc plus this cycle's vote.
  - If acc_next ≥ THRESH and gap counter = 0: code+1 at this edge, acc cleared to 0.
  - If acc_next ≤ -THRESH and gap counter = 0: code-1 at this edge, acc cleared to 0.
  - Latency: code changes on the same edge that samples the threshold-reaching vote, so it is visible 1 cycle after that vote is presented.
- Gap counter:
  - Loaded with MIN_GAP-1 on every step; decrements to 0 each RUN cycle.
  - Votes keep accumulating while the counter is nonzero.
  - If |acc| ≥ THRESH when the counter reaches 0, the step fires on the first cycle the counter reads 0.
- Wrap: increment from 2^CODE_W-1 gives 0; decrement from 0 gives 2^CODE_W-1. wrap pulses in the same cycle as the corresponding code_upd.
- code_upd pulses for 1 cycle after any step or load. It is not asserted if load_code equals the current code.
- load (any state): at the next edge, code=load_code, acc=0, gap counter=MIN_GAP-1, lock counter=0, lock=0.
  - load has priority over a simultaneous step.
  - load never asserts wrap.
  - load does not change state.
- Lock counter, per step:
  - Step direction opposite to the previous step: counter +1, saturating at LOCK_N.
  - Same direction as the previous step: counter=0.
  - lock=1 while counter=LOCK_N.
  - Direction memory is cleared on reset, load and entry to IDLE; the first step after any of these does not count.
- Width rules:
  - acc is FILT_W+1 bits signed.
  - Gap counter is clog2(MIN_GAP) bits; MIN_GAP=1 means no gap, so a step is allowed every cycle.
  - Code arithmetic is unsigned modulo 2^CODE_W.
- Reset asserted mid-operation clears everything immediately (async). After release, the first RUN edge starts from code=0.

Test Plan:
- Reset, en=1, up=1 constant (THRESH=4, MIN_GAP=8) -> code 0→1 one cycle after the 4th up vote, then +1 every 8 cycles; code_upd pulses each step; lock=0.
- load_code=6'h3F, then up stream -> next step gives code=0 with wrap=1 and code_upd=1. Repeat with load 0 and dn stream -> code=6'h3F, wrap=1.
- Alternating bursts of 4 up then 4 dn with MIN_GAP=1 -> code toggles N/N+1; lock asserts on the 4th reversal (LOCK_N=4); two same-direction steps clear it.
- freeze=1 after acc reaches +2, apply 20 dn votes, release -> code unchanged during freeze; acc resumes from +2; 6 dn votes needed to step -1.
- load strobe on the same cycle the step threshold is hit -> code=load_code (no ±1), acc=0, wrap=0, lock=0.
- up=dn=1 for 50 cycles; en toggled low mid-accumulation; rst_n pulsed low mid-gap -> no step; acc cleared in IDLE; all outputs 0 immediately on rst_n low.
